// File: rtl/sng_ctrl.sv
// sng_ctrl -- sequencing controller for a bank of stochastic number generators.
//
// Accepts a packed operand vector over a valid/ready handshake, drives the
// operands and one-cycle start/stop pulses to the SNG bank, counts the ones on
// each lane's stream bit for exactly STREAM_LEN cycles and presents the counts
// downstream over a second valid/ready handshake.
//
// Optional feature: define SNGC_BACKTOBACK_EN to allow a new operand vector to
// be accepted in DONE on the same edge the counts are consumed.
//
// Ports:
//   i_clk_sngc    clock
//   i_rstn_sngc   asynchronous active-low reset
//   i_valid_sngc  upstream operand vector valid
//   o_ready_sngc  controller accepts operands
//   i_x_sngc      packed operands, lane k at [k*XW +: XW]
//   i_abort_sngc  abort the current stream (START/RUN only)
//   o_x_bn        latched operands to the SNG bank
//   o_start_sng   one-cycle start pulse
//   o_stop_sng    one-cycle stop pulse
//   i_sn_bit      per-lane stream bits from the SNGs
//   o_cnt_sngc    per-lane ones counts, lane k at [k*CNT_W +: CNT_W]
//   o_valid_out   counts valid
//   i_ready_out   downstream accepts counts
//   o_busy_sngc   high in every state except IDLE
module sng_ctrl #(
    parameter int LANES      = 4,
    parameter int XW         = 4,
    parameter int STREAM_LEN = 16,
    parameter int CNT_W      = $clog2(STREAM_LEN + 1)
) (
    input  logic                   i_clk_sngc,
    input  logic                   i_rstn_sngc,
    input  logic                   i_valid_sngc,
    output logic                   o_ready_sngc,
    input  logic [LANES*XW-1:0]    i_x_sngc,
    input  logic                   i_abort_sngc,
    output logic [LANES*XW-1:0]    o_x_bn,
    output logic                   o_start_sng,
    output logic                   o_stop_sng,
    input  logic [LANES-1:0]       i_sn_bit,
    output logic [LANES*CNT_W-1:0] o_cnt_sngc,
    output logic                   o_valid_out,
    input  logic                   i_ready_out,
    output logic                   o_busy_sngc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_STOP,
        S_DONE
    } state_t;

    state_t                       state;
    state_t                       nxt;
    logic [CNT_W-1:0]             cyc;
    logic [LANES-1:0][CNT_W-1:0]  cnt;
    logic                         aborted;
    logic                         ready_q;
    logic                         in_stream;
    logic                         b2b_take;
    logic                         accept;

    assign in_stream = (state == S_START) || (state == S_RUN);

`ifdef SNGC_BACKTOBACK_EN
    // Consume the counts and accept the next vector on the same edge.
    assign b2b_take     = (state == S_DONE) && i_ready_out && i_valid_sngc;
    assign o_ready_sngc = ready_q | ((state == S_DONE) & i_ready_out);
`else
    assign b2b_take     = 1'b0;
    assign o_ready_sngc = ready_q;
`endif

    assign accept     = ((state == S_IDLE) && i_valid_sngc) || b2b_take;
    assign o_cnt_sngc = cnt;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (i_valid_sngc) nxt = S_START;
            S_START: nxt = i_abort_sngc ? S_STOP : S_RUN;
            S_RUN: begin
                if (i_abort_sngc || (cyc == CNT_W'(STREAM_LEN - 1)))
                    nxt = S_STOP;
            end
            S_STOP:  nxt = aborted ? S_IDLE : S_DONE;
            S_DONE: begin
                if (b2b_take)
                    nxt = S_START;
                else if (i_ready_out)
                    nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state, so they line
    // up with the state register without any path from the inputs.
    always_ff @(posedge i_clk_sngc or negedge i_rstn_sngc) begin
        if (!i_rstn_sngc) begin
            state       <= S_IDLE;
            cyc         <= '0;
            cnt         <= '0;
            o_x_bn      <= '0;
            aborted     <= 1'b0;
            ready_q     <= 1'b1;
            o_start_sng <= 1'b0;
            o_stop_sng  <= 1'b0;
            o_valid_out <= 1'b0;
            o_busy_sngc <= 1'b0;
        end else begin
            state       <= nxt;
            ready_q     <= (nxt == S_IDLE);
            o_start_sng <= (nxt == S_START);
            o_stop_sng  <= (nxt == S_STOP);
            o_valid_out <= (nxt == S_DONE);
            o_busy_sngc <= (nxt != S_IDLE);
            // Only meaningful while in STOP: remembers whether STOP was
            // entered through an abort.
            aborted     <= in_stream && i_abort_sngc;

            if (accept)
                o_x_bn <= i_x_sngc;

            case (state)
                S_START: begin
                    cnt <= '0;
                    cyc <= '0;
                end
                // The bit of an aborting RUN cycle is still counted.
                S_RUN: begin
                    for (int unsigned k = 0; k < LANES; k++)
                        cnt[k] <= cnt[k] + CNT_W'(i_sn_bit[k]);
                    cyc <= cyc + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sng_ctrl.sv
module tb_sng_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_x;
    logic        i_abort;
    logic [15:0] o_x_bn;
    logic        o_start;
    logic        o_stop;
    logic [3:0]  i_sn_bit;
    logic [19:0] o_cnt;
    logic        o_valid_out;
    logic        i_ready_out;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    sng_ctrl #(.LANES(4), .XW(4), .STREAM_LEN(16)) dut (
        .i_clk_sngc   (clk),
        .i_rstn_sngc  (rst_n),
        .i_valid_sngc (i_valid),
        .o_ready_sngc (o_ready),
        .i_x_sngc     (i_x),
        .i_abort_sngc (i_abort),
        .o_x_bn       (o_x_bn),
        .o_start_sng  (o_start),
        .o_stop_sng   (o_stop),
        .i_sn_bit     (i_sn_bit),
        .o_cnt_sngc   (o_cnt),
        .o_valid_out  (o_valid_out),
        .i_ready_out  (i_ready_out),
        .o_busy_sngc  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are sampled and inputs changed 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered during the START cycle. Drives bits that must be ignored in START,
    // then n RUN cycles where lane k is high while i < o_k. Returns in cycle n+2.
    task automatic drive_run(input int o3, input int o2, input int o1, input int o0, input int n);
        i_sn_bit = 4'hF;
        step();
        for (int i = 0; i < n; i++) begin
            i_sn_bit = {(i < o3), (i < o2), (i < o1), (i < o0)};
            step();
        end
        i_sn_bit = 4'hF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b1; i_x = 16'hFFFF; i_abort = 1'b0;
        i_sn_bit = 4'hF; i_ready_out = 1'b0;
        step(); step();
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_checks++;
        if ({o_start, o_stop, o_valid_out} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {o_start, o_stop, o_valid_out}); end
        n_checks++;
        if (o_x_bn !== 16'h0) begin n_fail++; $display("FAIL reset_x: got %h want 0000", o_x_bn); end
        n_checks++;
        if (o_cnt !== 20'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 00000", o_cnt); end
        n_checks++;
        i_valid = 1'b0; i_sn_bit = 4'h0;
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_stream();
        logic [19:0] exp_cnt;
        exp_cnt = {5'd9, 5'd16, 5'd0, 5'd6};
        i_x = {4'd9, 4'd15, 4'd0, 4'd6}; i_valid = 1'b1; i_ready_out = 1'b0;
        step();
        if (o_start !== 1'b1) begin n_fail++; $display("FAIL ss_start: got %b want 1", o_start); end
        n_checks++;
        if ({o_busy, o_ready} !== 2'b10) begin n_fail++; $display("FAIL ss_busy_ready: got %b want 10", {o_busy, o_ready}); end
        n_checks++;
        if (o_x_bn !== 16'h9F06) begin n_fail++; $display("FAIL ss_x_latched: got %h want 9f06", o_x_bn); end
        n_checks++;
        i_valid = 1'b0; i_x = 16'h0; i_sn_bit = 4'hF;
        step();
        for (int i = 0; i < 16; i++) begin
            i_sn_bit = {(i < 9), (i < 16), 1'b0, (i < 6)};
            if (i == 0) begin
                if (o_start !== 1'b0) begin n_fail++; $display("FAIL ss_start_width: got %b want 0", o_start); end
                n_checks++;
            end
            if ({o_stop, o_valid_out} !== 2'b00) begin n_fail++; $display("FAIL ss_run_%0d: stop/valid got %b want 00", i, {o_stop, o_valid_out}); end
            n_checks++;
            step();
        end
        i_sn_bit = 4'hF;
        if ({o_stop, o_valid_out} !== 2'b10) begin n_fail++; $display("FAIL ss_stop: stop/valid got %b want 10", {o_stop, o_valid_out}); end
        n_checks++;
        step();
        if ({o_stop, o_valid_out} !== 2'b01) begin n_fail++; $display("FAIL ss_valid: stop/valid got %b want 01", {o_stop, o_valid_out}); end
        n_checks++;
        if (o_cnt !== exp_cnt) begin n_fail++; $display("FAIL ss_counts: got %h want %h", o_cnt, exp_cnt); end
        n_checks++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL ss_done_ready: got %b want 0", o_ready); end
        n_checks++;
    endtask

    // Entered in DONE of the single stream with i_ready_out low.
    task automatic test_backpressure();
        logic [19:0] exp_cnt;
        exp_cnt = {5'd9, 5'd16, 5'd0, 5'd6};
        i_valid = 1'b1; i_x = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            if ({o_valid_out, o_ready, o_start} !== 3'b100) begin n_fail++; $display("FAIL bp_hold_%0d: valid/ready/start got %b want 100", i, {o_valid_out, o_ready, o_start}); end
            n_checks++;
            if (o_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_cnt_%0d: got %h want %h", i, o_cnt, exp_cnt); end
            n_checks++;
            if (o_x_bn !== 16'h9F06) begin n_fail++; $display("FAIL bp_x_%0d: got %h want 9f06", i, o_x_bn); end
            n_checks++;
        end
        i_ready_out = 1'b1;
        step();
`ifndef SNGC_BACKTOBACK_EN
        if ({o_valid_out, o_ready, o_busy, o_start} !== 4'b0100) begin n_fail++; $display("FAIL bp_idle: valid/ready/busy/start got %b want 0100", {o_valid_out, o_ready, o_busy, o_start}); end
        n_checks++;
        step();
`endif
        if (o_start !== 1'b1) begin n_fail++; $display("FAIL bp_accept: start got %b want 1", o_start); end
        n_checks++;
        if (o_x_bn !== 16'h1234) begin n_fail++; $display("FAIL bp_x_new: got %h want 1234", o_x_bn); end
        n_checks++;
        i_valid = 1'b0; i_ready_out = 1'b0;
        drive_run(1, 2, 3, 4, 16);
        step();
        if (o_cnt !== {5'd1, 5'd2, 5'd3, 5'd4}) begin n_fail++; $display("FAIL bp_cnt2: got %h want %h", o_cnt, {5'd1, 5'd2, 5'd3, 5'd4}); end
        n_checks++;
        i_ready_out = 1'b1;
        step();
        i_ready_out = 1'b0;
    endtask

    task automatic test_abort();
        logic [19:0] exp_cnt;
        exp_cnt = {5'd7, 5'd3, 5'd0, 5'd5};
        i_x = 16'h7305; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        drive_run(7, 3, 0, 5, 7);
        i_sn_bit = 4'h0; i_abort = 1'b1;
        step();
        i_abort = 1'b0; i_sn_bit = 4'hF;
        if ({o_stop, o_valid_out} !== 2'b10) begin n_fail++; $display("FAIL ab_stop: stop/valid got %b want 10", {o_stop, o_valid_out}); end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            step();
            if ({o_valid_out, o_ready, o_busy, o_stop} !== 4'b0100) begin n_fail++; $display("FAIL ab_idle_%0d: valid/ready/busy/stop got %b want 0100", i, {o_valid_out, o_ready, o_busy, o_stop}); end
            n_checks++;
            if (o_cnt !== exp_cnt) begin n_fail++; $display("FAIL ab_partial_%0d: got %h want %h", i, o_cnt, exp_cnt); end
            n_checks++;
        end
        // Abort coinciding with an accept in IDLE is ignored.
        i_x = 16'hA5C3; i_valid = 1'b1; i_abort = 1'b1;
        step();
        i_valid = 1'b0; i_abort = 1'b0;
        if (o_start !== 1'b1) begin n_fail++; $display("FAIL ab_idle_accept: start got %b want 1", o_start); end
        n_checks++;
        drive_run(4, 8, 12, 16, 16);
        if (o_stop !== 1'b1) begin n_fail++; $display("FAIL ab_normal_stop: got %b want 1", o_stop); end
        n_checks++;
        step();
        if (o_valid_out !== 1'b1) begin n_fail++; $display("FAIL ab_normal_valid: got %b want 1", o_valid_out); end
        n_checks++;
        if (o_cnt !== {5'd4, 5'd8, 5'd12, 5'd16}) begin n_fail++; $display("FAIL ab_normal_cnt: got %h want %h", o_cnt, {5'd4, 5'd8, 5'd12, 5'd16}); end
        n_checks++;
        i_ready_out = 1'b1;
        step();
        i_ready_out = 1'b0;
    endtask

    task automatic test_async_reset();
        i_x = 16'hBEEF; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        drive_run(16, 16, 16, 16, 4);
        #2 rst_n = 1'b0;
        #1;
        if ({o_busy, o_ready, o_stop, o_start} !== 4'b0100) begin n_fail++; $display("FAIL ar_idle: busy/ready/stop/start got %b want 0100", {o_busy, o_ready, o_stop, o_start}); end
        n_checks++;
        if (o_cnt !== 20'h0) begin n_fail++; $display("FAIL ar_cnt: got %h want 00000", o_cnt); end
        n_checks++;
        step();
        if (o_stop !== 1'b0) begin n_fail++; $display("FAIL ar_no_stop: got %b want 0", o_stop); end
        n_checks++;
        #2 rst_n = 1'b1;
        i_sn_bit = 4'h0;
        step();
    endtask

    task automatic test_back_to_back();
        i_x = 16'h1111; i_valid = 1'b1; i_ready_out = 1'b1;
        step();
        if (o_start !== 1'b1) begin n_fail++; $display("FAIL bb_start1: got %b want 1", o_start); end
        n_checks++;
        i_x = 16'h2222;
        drive_run(2, 4, 6, 8, 16);
        step();
        if (o_valid_out !== 1'b1) begin n_fail++; $display("FAIL bb_valid1: got %b want 1", o_valid_out); end
        n_checks++;
        if (o_cnt !== {5'd2, 5'd4, 5'd6, 5'd8}) begin n_fail++; $display("FAIL bb_cnt1: got %h want %h", o_cnt, {5'd2, 5'd4, 5'd6, 5'd8}); end
        n_checks++;
`ifdef SNGC_BACKTOBACK_EN
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bb_done_ready: got %b want 1", o_ready); end
        n_checks++;
        step();
`else
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bb_done_ready: got %b want 0", o_ready); end
        n_checks++;
        step();
        if ({o_start, o_ready, o_busy} !== 3'b010) begin n_fail++; $display("FAIL bb_gap_idle: start/ready/busy got %b want 010", {o_start, o_ready, o_busy}); end
        n_checks++;
        step();
`endif
        if (o_start !== 1'b1) begin n_fail++; $display("FAIL bb_start2: got %b want 1", o_start); end
        n_checks++;
        if (o_x_bn !== 16'h2222) begin n_fail++; $display("FAIL bb_x2: got %h want 2222", o_x_bn); end
        n_checks++;
        i_valid = 1'b0;
        drive_run(16, 0, 1, 15, 16);
        step();
        if (o_valid_out !== 1'b1) begin n_fail++; $display("FAIL bb_valid2: got %b want 1", o_valid_out); end
        n_checks++;
        if (o_cnt !== {5'd16, 5'd0, 5'd1, 5'd15}) begin n_fail++; $display("FAIL bb_cnt2: got %h want %h", o_cnt, {5'd16, 5'd0, 5'd1, 5'd15}); end
        n_checks++;
        step();
        if ({o_valid_out, o_ready} !== 2'b01) begin n_fail++; $display("FAIL bb_drain: valid/ready got %b want 01", {o_valid_out, o_ready}); end
        n_checks++;
        i_ready_out = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
